// File: rtl/spectro_pkg.sv
// Shared constants and state encoding for the spectrogram serial-link receiver.
package spectro_pkg;

   localparam int WORD_W = 12;                    // bits per serial word
   localparam int NUM_CH = 16;                    // words per frame
   localparam int CH_W   = 4;                     // channel address width
   localparam int FCNT_W = 8;                     // completed-frame counter width
   localparam int BCNT_W = $clog2(WORD_W + 1);    // bit counter must hold WORD_W

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/word_shift_rx.sv
// Serial word capture: detects the SL load->shift transition, counts MSB-first
// bits into a shift register and reports either a completed word or a
// truncation as single-cycle combinational events for the top to register.
module word_shift_rx
   import spectro_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              sl_in,
   input  logic [CH_W-1:0]   sel_in,
   input  logic              ovf_in,
   output logic              done,
   output logic [WORD_W-1:0] done_data,
   output logic [CH_W-1:0]   done_ch,
   output logic              done_ovf,
   output logic              trunc
);

   state_t              state_q, state_d;
   logic                sl_q;
   logic [BCNT_W-1:0]   bitcnt;
   logic [WORD_W-1:0]   shreg;
   logic [CH_W-1:0]     ch_sh;
   logic                ovf_sh;
   logic                start, shift;

   // Next-state and event decode; sl_q=1 means the shifter was loaded last cycle (armed).
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      shift   = 1'b0;
      done    = 1'b0;
      trunc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!sl_in && sl_q) begin
               start   = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (sl_in) begin
               // load before the last bit arrived: word is lost
               trunc   = 1'b1;
               state_d = IDLE;
            end else begin
               shift = 1'b1;
               if (bitcnt == BCNT_W'(WORD_W - 1)) begin
                  done    = 1'b1;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (sl_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The final bit is folded in directly so the word is usable on the completing edge.
   assign done_data = {shreg[WORD_W-2:0], serial_in};
   assign done_ch   = ch_sh;
   assign done_ovf  = ovf_sh;

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Shift datapath: arm flag, bit counter, shift register and start-of-word shadows.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sl_q   <= 1'b0;
         bitcnt <= '0;
         shreg  <= '0;
         ch_sh  <= '0;
         ovf_sh <= 1'b0;
      end else begin
         sl_q <= sl_in;
         if (start) begin
            shreg  <= {{(WORD_W-1){1'b0}}, serial_in};
            bitcnt <= BCNT_W'(1);
            ch_sh  <= sel_in;
            ovf_sh <= ovf_in;
         end else if (shift) begin
            shreg  <= {shreg[WORD_W-2:0], serial_in};
            bitcnt <= bitcnt + BCNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/frame_deserializer.sv
// Spectrogram link receiver top: registers captured words, checks channel
// ordering across 16-word frames, counts completed frames and keeps sticky
// error flags. Define FRAME_BUF_EN to add a frame shadow buffer with a
// registered read port (rd_addr/rd_data).
module frame_deserializer
   import spectro_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              serial_in,
   input  logic              sl_in,
   input  logic [CH_W-1:0]   sel_in,
   input  logic              ovf_in,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_data,
   output logic [CH_W-1:0]   word_ch,
   output logic              word_ovf,
   output logic              frame_done,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              seq_err,
   output logic              trunc_err
`ifdef FRAME_BUF_EN
   ,
   input  logic [CH_W-1:0]   rd_addr,
   output logic [WORD_W-1:0] rd_data
`endif
);

   logic              done, trunc, done_ovf;
   logic [WORD_W-1:0] done_data;
   logic [CH_W-1:0]   done_ch;
   logic [CH_W-1:0]   exp_ch;
   logic              in_order, last_ch, frame_end;

   word_shift_rx u_rx (
      .clk       (clk),
      .reset     (reset),
      .serial_in (serial_in),
      .sl_in     (sl_in),
      .sel_in    (sel_in),
      .ovf_in    (ovf_in),
      .done      (done),
      .done_data (done_data),
      .done_ch   (done_ch),
      .done_ovf  (done_ovf),
      .trunc     (trunc)
   );

   assign in_order  = (done_ch == exp_ch);
   assign last_ch   = (done_ch == CH_W'(NUM_CH - 1));
   assign frame_end = done && in_order && last_ch;

   // Word output register: strobe for one cycle, payload held until the next word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_ch    <= '0;
         word_ovf   <= 1'b0;
      end else begin
         word_valid <= done;
         if (done) begin
            word_data <= done_data;
            word_ch   <= done_ch;
            word_ovf  <= done_ovf;
         end
      end
   end

   // Frame sequencing, frame counter and sticky error flags; a ch0 word always restarts a frame.
   always_ff @(posedge clk) begin
      if (!reset) begin
         exp_ch     <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         seq_err    <= 1'b0;
         trunc_err  <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (trunc) begin
            trunc_err <= 1'b1;
            exp_ch    <= '0;
         end else if (done) begin
            if (in_order) begin
               exp_ch <= last_ch ? '0 : exp_ch + CH_W'(1);
            end else begin
               seq_err <= 1'b1;
               exp_ch  <= (done_ch == '0) ? CH_W'(1) : '0;
            end
         end
         if (frame_end) frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end

`ifdef FRAME_BUF_EN
   logic [WORD_W-1:0] stage    [NUM_CH];
   logic [WORD_W-1:0] frame_buf[NUM_CH];

   // Words land in staging; only an in-order completed frame is copied to the readable buffer.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            stage[i]     <= '0;
            frame_buf[i] <= '0;
         end
         rd_data <= '0;
      end else begin
         if (done) stage[done_ch] <= done_data;
         if (frame_end) begin
            for (int i = 0; i < NUM_CH; i++)
               frame_buf[i] <= (CH_W'(i) == done_ch) ? done_data : stage[i];
         end
         rd_data <= frame_buf[rd_addr];
      end
   end
`endif

endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: directed phases plus randomized
// words, compared against a transaction-level model of the frame rules.
module tb_frame_deserializer;
   import spectro_pkg::*;

   logic              clk = 1'b0;
   logic              reset, serial_in, sl_in, ovf_in;
   logic [CH_W-1:0]   sel_in;
   logic              word_valid, word_ovf, frame_done, seq_err, trunc_err;
   logic [WORD_W-1:0] word_data;
   logic [CH_W-1:0]   word_ch;
   logic [FCNT_W-1:0] frame_cnt;
`ifdef FRAME_BUF_EN
   logic [CH_W-1:0]   rd_addr;
   logic [WORD_W-1:0] rd_data;
`endif

   frame_deserializer dut (
      .clk        (clk),
      .reset      (reset),
      .serial_in  (serial_in),
      .sl_in      (sl_in),
      .sel_in     (sel_in),
      .ovf_in     (ovf_in),
      .word_valid (word_valid),
      .word_data  (word_data),
      .word_ch    (word_ch),
      .word_ovf   (word_ovf),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .seq_err    (seq_err),
      .trunc_err  (trunc_err)
`ifdef FRAME_BUF_EN
      ,
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state
   int          m_exp, m_frames, m_words;
   bit          m_seq, m_trunc, pending;
   logic [11:0] m_stage [16];
   logic [11:0] m_buf   [16];

   // independent count of strobes to catch spurious or doubled pulses
   int vld_seen = 0;
   always @(negedge clk) if (word_valid === 1'b1) vld_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; sl_in = 1'b0; serial_in = 1'b0; sel_in = '0; ovf_in = 1'b0;
`ifdef FRAME_BUF_EN
      rd_addr = '0;
`endif
      tick(); tick();
      chk("rst_word_valid", word_valid, 0);
      chk("rst_word_data",  word_data,  0);
      chk("rst_word_ch",    word_ch,    0);
      chk("rst_word_ovf",   word_ovf,   0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_cnt",  frame_cnt,  0);
      chk("rst_seq_err",    seq_err,    0);
      chk("rst_trunc_err",  trunc_err,  0);
`ifdef FRAME_BUF_EN
      chk("rst_rd_data",    rd_data,    0);
`endif
      reset = 1'b1;
      m_exp = 0; m_frames = 0; m_seq = 0; m_trunc = 0; pending = 0;
      for (int i = 0; i < 16; i++) begin m_stage[i] = '0; m_buf[i] = '0; end
   endtask

   // One transaction: load cycle, nbits MSB-first shift cycles, then hold cycles
   // if the word completed. A partial word is only judged truncated when the next
   // load arrives.
   task automatic send_word(input int ch, input logic [11:0] data, input int nbits, input int extra);
      logic ovf;
      bit   fd;
      ovf = 1'($urandom_range(0, 1));
      sl_in = 1'b1; sel_in = 4'($urandom); ovf_in = 1'($urandom); serial_in = 1'($urandom);
      tick();
      if (pending) begin pending = 0; m_trunc = 1; m_exp = 0; end
      chk("trunc_err_at_load", trunc_err, m_trunc);
      chk("no_valid_at_load", word_valid, 0);
      for (int i = 0; i < nbits; i++) begin
         sl_in = 1'b0;
         serial_in = data[11 - i];
         if (i == 0) begin sel_in = 4'(ch); ovf_in = ovf; end
         else begin sel_in = 4'($urandom); ovf_in = 1'($urandom); end
         tick();
         if (i < 11) chk("no_valid_mid_word", word_valid, 0);
      end
      if (nbits == 12) begin
         fd = 0;
         m_words++;
         m_stage[ch] = data;
         if (ch == m_exp) begin
            if (ch == 15) begin
               fd = 1;
               m_frames = (m_frames + 1) % 256;
               for (int k = 0; k < 16; k++) m_buf[k] = m_stage[k];
            end
            m_exp = (ch + 1) % 16;
         end else begin
            m_seq = 1;
            m_exp = (ch == 0) ? 1 : 0;
         end
         chk("word_valid",  word_valid, 1);
         chk("word_data",   word_data,  data);
         chk("word_ch",     word_ch,    ch);
         chk("word_ovf",    word_ovf,   ovf);
         chk("frame_done",  frame_done, fd);
         chk("frame_cnt",   frame_cnt,  m_frames);
         chk("seq_err",     seq_err,    m_seq);
         chk("trunc_err",   trunc_err,  m_trunc);
         for (int e = 0; e < extra; e++) begin
            sl_in = 1'b0; serial_in = 1'($urandom); sel_in = 4'($urandom);
            tick();
            chk("valid_one_cycle", word_valid, 0);
            chk("frame_done_one_cycle", frame_done, 0);
            chk("word_data_hold", word_data, data);
         end
      end else if (nbits > 0) begin
         pending = 1;
      end
   endtask

   task automatic send_frame(input bit patterned);
      for (int c = 0; c < 16; c++)
         send_word(c, patterned ? 12'(c * 12'h101) : 12'($urandom), 12, 1);
   endtask

   initial begin
      m_words = 0;

      // reset, then sl_in held low: nothing may be captured
      do_reset();
      for (int i = 0; i < 20; i++) begin
         sl_in = 1'b0; serial_in = 1'($urandom); sel_in = 4'($urandom); ovf_in = 1'($urandom);
         tick();
         chk("idle_no_valid", word_valid, 0);
         chk("idle_word_data", word_data, 0);
         chk("idle_frame_cnt", frame_cnt, 0);
      end

      // single word 0xA5C on channel 3
      send_word(3, 12'hA5C, 12, 2);

      // clean patterned frame
      do_reset();
      send_frame(1'b1);
      chk("frame1_cnt", frame_cnt, 1);
      chk("frame1_seq", seq_err, 0);
      chk("frame1_trunc", trunc_err, 0);

      // truncation after 7 bits, then a good frame still completes
      send_word(0, 12'($urandom), 7, 0);
      send_frame(1'b0);
      chk("after_trunc_cnt", frame_cnt, 2);
      chk("after_trunc_flag", trunc_err, 1);
      // load exactly where the 12th bit would arrive
      send_word(0, 12'($urandom), 11, 0);
      send_word(0, 12'($urandom), 12, 1);

      // randomized mix of in-order, out-of-order, partial and empty words
      for (int n = 0; n < 60; n++) begin
         int r, ch, nb;
         r  = $urandom_range(0, 9);
         ch = (r < 7) ? m_exp : $urandom_range(0, 15);
         nb = (r == 9) ? $urandom_range(0, 11) : 12;
         send_word(ch, 12'($urandom), nb, $urandom_range(1, 2));
      end

      // order 0,1,3 flags seq_err; 256 good frames wrap the counter
      do_reset();
      send_word(0, 12'($urandom), 12, 1);
      send_word(1, 12'($urandom), 12, 1);
      send_word(3, 12'($urandom), 12, 1);
      chk("seq_err_set", seq_err, 1);
      for (int f = 0; f < 256; f++) send_frame(1'b0);
      chk("frame_cnt_wrap", frame_cnt, 0);
      chk("seq_err_sticky", seq_err, 1);

`ifdef FRAME_BUF_EN
      // buffer read after a good frame, then an aborted frame must not disturb it
      do_reset();
      send_frame(1'b1);
      rd_addr = 4'd5; tick();
      chk("rd_data_5", rd_data, 12'h505);
      for (int c = 0; c < 5; c++) send_word(c, 12'($urandom), 12, 1);
      send_word(5, 12'($urandom), 5, 0);
      send_word(0, 12'($urandom), 12, 1);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); tick();
         chk("rd_data_kept", rd_data, m_buf[a]);
      end
      send_frame(1'b0);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a); tick();
         chk("rd_data_new", rd_data, m_buf[a]);
      end
`endif

      tick();
      chk("word_valid_count", vld_seen, m_words);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // safety net against a stalled run
   initial begin
      #5000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
